// File: rtl/aes128_package.sv
// rtl/aes128_package.sv - shared constants, types and helpers for the masked AES datapath
package aes128_package;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } rand_state_e;

  localparam logic [31:0] LFSR_MASK      = 32'h80200003;
  localparam logic [31:0] ZERO_SEED_BASE = 32'hACE10000;

  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Thirty-two single-bit Galois steps, so each lane update yields a fully fresh word.
  function automatic logic [31:0] lfsr_step32(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++) begin
      if (r[0]) r = (r >> 1) ^ LFSR_MASK;
      else      r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hpc3_rand_gen_lane.sv
// rtl/hpc3_rand_gen_lane.sv - one 32-bit Galois LFSR lane with load and step controls
// Only the low OUT_BITS of the state leave the lane; the rest stay internal as feedback.
module hpc3_lfsr_lane
  import aes128_package::*;
#(
  parameter int OUT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [31:0]         load_data,
  input  logic                step,
  output logic [OUT_BITS-1:0] out_state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load)      state_d = load_data;
    else if (step) state_d = lfsr_step32(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign out_state = state_q[OUT_BITS-1:0];

endmodule

// File: rtl/hpc3_rand_gen.sv
// rtl/hpc3_rand_gen.sv - seeded LFSR bank supplying in_r/in_p randomness to hpc3_mul gadgets
module hpc3_rand_gen
  import aes128_package::*;
#(
  parameter int NUM_SHARES    = 3,
  parameter int BIT_WIDTH     = 1,
  parameter int NUM_OUTPUTS   = 2,
  parameter int WARMUP_CYCLES = 16,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic [31:0] in_seed,
  input  logic        in_seed_valid,
  output logic        out_seed_ready,
  input  logic        in_reseed,
  input  logic        in_enable,
  output logic [NUM_OUTPUTS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_r,
  output logic [NUM_OUTPUTS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_p,
  output logic        out_valid
);

  localparam int RAND_BITS = 2 * NUM_OUTPUTS * NUM_QUADRATIC * BIT_WIDTH;
  localparam int HALF_BITS = RAND_BITS / 2;
  localparam int N_LANES   = (RAND_BITS + 31) / 32;
  localparam int WCW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int UCW       = $clog2(WARMUP_CYCLES + 1);

  rand_state_e    state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [UCW-1:0] warm_cnt_q, warm_cnt_d;
  logic [N_LANES-1:0] lane_load;
  logic               lane_step;
  logic [RAND_BITS-1:0] pool;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    warm_cnt_d = warm_cnt_q;
    lane_load  = '0;
    lane_step  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_seed_valid) begin
          for (int i = 0; i < N_LANES; i++) lane_load[i] = (word_cnt_q == WCW'(i));
          if (word_cnt_q == WCW'(N_LANES - 1)) begin
            state_d    = ST_WARMUP;
            word_cnt_d = '0;
            warm_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      ST_WARMUP: begin
        lane_step = 1'b1;
        if (warm_cnt_q == UCW'(WARMUP_CYCLES - 1)) begin
          state_d    = ST_RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + UCW'(1);
        end
      end
      ST_RUN: begin
        // Reseed wins over enable so the lanes are not advanced on the way out.
        if (in_reseed) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
        end else if (in_enable) begin
          lane_step = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= ST_LOAD;
      word_cnt_q <= '0;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    localparam int LANE_BITS = (RAND_BITS - g * 32 >= 32) ? 32 : RAND_BITS - g * 32;
    logic [31:0] seed_word;
    // An all-zero seed would lock the LFSR, so substitute a lane-unique constant.
    assign seed_word = (in_seed == 32'd0) ? (ZERO_SEED_BASE | 32'(g)) : in_seed;

    hpc3_lfsr_lane #(
      .OUT_BITS(LANE_BITS)
    ) u_lane (
      .clk      (in_clock),
      .reset    (in_reset),
      .load     (lane_load[g]),
      .load_data(seed_word),
      .step     (lane_step),
      .out_state(pool[g*32 +: LANE_BITS])
    );
  end

  assign out_valid      = (state_q == ST_RUN);
  assign out_seed_ready = (state_q == ST_LOAD);
  assign out_r          = out_valid ? pool[HALF_BITS-1:0]         : '0;
  assign out_p          = out_valid ? pool[RAND_BITS-1:HALF_BITS] : '0;

endmodule
